// File: rtl/tile_feeder.sv
// rtl/tile_feeder.sv - stages DEPTH row words, parallel-loads them into transpose_fifo, then paces the shifts
// Optional TILE_FEEDER_ZERO_PAD_EN adds in_last, which closes a short tile and zero-pads the rest.
module tile_feeder #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [BITS-1:0]             in_data,
`ifdef TILE_FEEDER_ZERO_PAD_EN
  input  logic                        in_last,
`endif
  output logic                        in_ready,
  input  logic                        drain_ready,
  output logic [DEPTH-1:0][BITS-1:0]  fifo_d,
  output logic                        fifo_wren,
  output logic                        fifo_en,
  output logic                        tile_done,
  output logic                        busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]              buf_cnt;
  logic [CW-1:0]              drain_cnt;
  logic [DEPTH-1:0][BITS-1:0] tile_buf;
  logic                       live;
  logic                       accept;

  assign in_ready  = (buf_cnt != CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  // Load waits for the FIFO to finish shifting the previous tile, so wren and en never overlap.
  assign fifo_wren = (buf_cnt == CW'(DEPTH)) && !live;
  assign fifo_en   = live && drain_ready;
  assign fifo_d    = tile_buf;
  assign busy      = (buf_cnt != '0) || live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_cnt   <= '0;
      drain_cnt <= '0;
      tile_buf  <= '0;
      live      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;

      if (accept) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (buf_cnt == CW'(k)) tile_buf[k] <= in_data;
        end
`ifdef TILE_FEEDER_ZERO_PAD_EN
        if (in_last) begin
          // Entries after the last word are cleared so a short tile drains with trailing zeros.
          for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) > buf_cnt) tile_buf[k] <= '0;
          end
          buf_cnt <= CW'(DEPTH);
        end else begin
          buf_cnt <= buf_cnt + CW'(1);
        end
`else
        buf_cnt <= buf_cnt + CW'(1);
`endif
      end

      if (fifo_wren) begin
        buf_cnt   <= '0;
        live      <= 1'b1;
        drain_cnt <= '0;
      end

      if (fifo_en) begin
        drain_cnt <= drain_cnt + CW'(1);
        if (drain_cnt == CW'(DEPTH - 1)) begin
          live      <= 1'b0;
          tile_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_feeder.sv
// tb/tb_tile_feeder.sv - directed self-checking bench for tile_feeder
module tb_tile_feeder;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_n;
  logic                       in_valid;
  logic [BITS-1:0]            in_data;
  logic                       in_ready;
  logic                       drain_ready;
  logic [DEPTH-1:0][BITS-1:0] fifo_d;
  logic                       fifo_wren;
  logic                       fifo_en;
  logic                       tile_done;
  logic                       busy;
`ifdef TILE_FEEDER_ZERO_PAD_EN
  logic                       in_last;
`endif

  tile_feeder #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
`ifdef TILE_FEEDER_ZERO_PAD_EN
    .in_last     (in_last),
`endif
    .in_ready    (in_ready),
    .drain_ready (drain_ready),
    .fifo_d      (fifo_d),
    .fifo_wren   (fifo_wren),
    .fifo_en     (fifo_en),
    .tile_done   (tile_done),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] w(input int k);
    return 64'h0101010101010101 * 64'(k);
  endfunction

  function automatic logic [63:0] tb_b(input int k);
    return 64'hB5B5_0000_0000_0000 | 64'(k + 1);
  endfunction

  task automatic push_word(input string tag, input logic [63:0] data);
    in_valid = 1'b1;
    in_data  = data;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_wren"}, 64'(fifo_wren), 64'd0);
    chk({tag, "_en"}, 64'(fifo_en), 64'd0);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain_tile(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid    = 1'b0;
      drain_ready = 1'b1;
      #1;
      chk({tag, "_en"}, 64'(fifo_en), 64'd1);
      chk({tag, "_wren"}, 64'(fifo_wren), 64'd0);
      chk({tag, "_done_early"}, 64'(tile_done), 64'd0);
      cyc();
    end
    #1;
    chk({tag, "_done"}, 64'(tile_done), 64'd1);
    chk({tag, "_en_after"}, 64'(fifo_en), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    cyc();
  endtask

  initial begin
    int en_cnt;
    int wren_cnt;
    int widx;
    logic exp_wren;
    logic exp_en;
    logic exp_done;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    drain_ready = 1'b0;
`ifdef TILE_FEEDER_ZERO_PAD_EN
    in_last     = 1'b0;
`endif

    // 1: reset
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wren", 64'(fifo_wren), 64'd0);
    chk("rst_en", 64'(fifo_en), 64'd0);
    chk("rst_done", 64'(tile_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < DEPTH; k++) chk("rst_fifo_d", fifo_d[k], 64'd0);
    cyc();

    // 2: single tile, drain_ready high throughout (ignored while not live)
    drain_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) push_word("t2_fill", w(k));
    #1;
    chk("t2_wren", 64'(fifo_wren), 64'd1);
    chk("t2_wren_en", 64'(fifo_en), 64'd0);
    chk("t2_full_in_ready", 64'(in_ready), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    for (int k = 0; k < DEPTH; k++) chk("t2_fifo_d", fifo_d[k], w(k));
    cyc();
    drain_tile("t2_drain");
    #1;
    chk("t2_done_pulse", 64'(tile_done), 64'd0);
    cyc();

    // 3: back-pressure with a second tile filling during the drain
    drain_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_word("t3_fill", w(k + 8));
    #1;
    chk("t3_wren_a", 64'(fifo_wren), 64'd1);
    cyc();
    en_cnt = 0;
    for (int d = 0; d < 15; d++) begin
      drain_ready = (d % 2 == 0);
      in_valid    = 1'b1;
      in_data     = (d < DEPTH) ? tb_b(d) : 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      chk("t3_en_gated", 64'(fifo_en), 64'(d % 2 == 0));
      chk("t3_no_wren", 64'(fifo_wren), 64'd0);
      chk("t3_in_ready", 64'(in_ready), 64'(d < DEPTH));
      if (fifo_en) en_cnt++;
      cyc();
    end
    in_valid    = 1'b0;
    drain_ready = 1'b1;
    #1;
    chk("t3_en_count", 64'(en_cnt), 64'd8);
    chk("t3_wren_b", 64'(fifo_wren), 64'd1);
    chk("t3_wren_b_en", 64'(fifo_en), 64'd0);
    chk("t3_done_a", 64'(tile_done), 64'd1);
    for (int k = 0; k < DEPTH; k++) chk("t3_fifo_d_b", fifo_d[k], tb_b(k));
    cyc();
    drain_tile("t3_drain_b");

`ifdef TILE_FEEDER_ZERO_PAD_EN
    // 6: short tile closed by in_last; stale entries from tile B must read back as zero
    push_word("t6_fill", w(0));
    push_word("t6_fill", w(1));
    in_last = 1'b1;
    push_word("t6_last", w(2));
    in_last = 1'b0;
    #1;
    chk("t6_wren", 64'(fifo_wren), 64'd1);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < DEPTH; k++) chk("t6_fifo_d", fifo_d[k], (k < 3) ? w(k) : 64'd0);
    cyc();
    drain_tile("t6_drain");
`endif

    // 4: streaming, five tiles
    drain_ready = 1'b1;
    en_cnt   = 0;
    wren_cnt = 0;
    widx     = 0;
    for (int c = 0; c < 53; c++) begin
      in_valid = (c < 44);
      in_data  = {32'hC0DE_0000, 32'(widx)};
      #1;
      exp_wren = (c >= 8) && ((c - 8) % 9 == 0);
      exp_en   = (c >= 9) && ((c - 8) % 9 != 0);
      exp_done = (c >= 17) && ((c - 17) % 9 == 0);
      chk("t4_wren", 64'(fifo_wren), 64'(exp_wren));
      chk("t4_en", 64'(fifo_en), 64'(exp_en));
      chk("t4_done", 64'(tile_done), 64'(exp_done));
      chk("t4_coincide", 64'(fifo_wren && fifo_en), 64'd0);
      if (fifo_wren) begin
        for (int k = 0; k < DEPTH; k++)
          chk("t4_fifo_d", fifo_d[k], {32'hC0DE_0000, 32'(wren_cnt * 8 + k)});
        wren_cnt++;
      end
      if (fifo_en) en_cnt++;
      if (in_valid && in_ready) widx++;
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("t4_en_total", 64'(en_cnt), 64'd40);
    chk("t4_wren_total", 64'(wren_cnt), 64'd5);
    chk("t4_last_done", 64'(tile_done), 64'd1);
    chk("t4_idle_busy", 64'(busy), 64'd0);
    cyc();

    // 5: reset after three shifts
    for (int k = 0; k < DEPTH; k++) push_word("t5_fill", w(k + 3));
    #1;
    chk("t5_wren", 64'(fifo_wren), 64'd1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_pre_en", 64'(fifo_en), 64'd1);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_wren_rst", 64'(fifo_wren), 64'd0);
    chk("t5_done_rst", 64'(tile_done), 64'd0);
    chk("t5_busy_rst", 64'(busy), 64'd0);
    for (int k = 0; k < DEPTH; k++) chk("t5_fifo_d_rst", fifo_d[k], 64'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t5_no_en", 64'(fifo_en), 64'd0);
      chk("t5_no_done", 64'(tile_done), 64'd0);
      cyc();
    end
    for (int k = 0; k < DEPTH; k++) push_word("t5_refill", w(k + 1));
    #1;
    chk("t5_rewren", 64'(fifo_wren), 64'd1);
    for (int k = 0; k < DEPTH; k++) chk("t5_fifo_d_new", fifo_d[k], w(k + 1));
    cyc();
    drain_tile("t5_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
